// File: rtl/noc_pkg.sv
// Shared router definitions.
//   P                      number of router ports
//   LOCAL..SOUTH           one-hot port codes, bit order {S,W,N,E,L}
//   port_state_e           input-port FSM states
//   head_idx/tail_idx/...  bit positions of the flit fields
package noc_pkg;

  localparam int P = 5;

  localparam logic [P-1:0] LOCAL = 5'b00001;
  localparam logic [P-1:0] EAST  = 5'b00010;
  localparam logic [P-1:0] NORTH = 5'b00100;
  localparam logic [P-1:0] WEST  = 5'b01000;
  localparam logic [P-1:0] SOUTH = 5'b10000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    ACTIVE = 2'd2
  } port_state_e;

  // Head flag is the flit MSB.
  function automatic int head_idx(input int fw);
    return fw - 1;
  endfunction

  // Tail flag sits just below the head flag.
  function automatic int tail_idx(input int fw);
    return fw - 2;
  endfunction

  // Destination x starts at bit 0 of a head flit.
  function automatic int dest_x_lsb();
    return 0;
  endfunction

  // Destination y follows destination x.
  function automatic int dest_y_lsb(input int xw);
    return xw;
  endfunction

endpackage

// File: rtl/xy_mesh_routing.sv
// Dimension-ordered (X first, then Y) route computation for a 2D mesh.
// Purely combinational.
//   i_current_x/y  this router's address
//   i_dest_x/y     destination address from the head flit
//   o_destport     output port: one-hot {S,W,N,E,L} when OUT_BIN=0,
//                  binary index (L=0,E=1,N=2,W=3,S=4) when OUT_BIN=1
// Increasing x is EAST, increasing y is SOUTH.
module xy_mesh_routing
  import noc_pkg::*;
#(
  parameter int NX      = 4,
  parameter int NY      = 3,
  parameter int Xw      = 2,
  parameter int Yw      = 2,
  parameter bit OUT_BIN = 1'b0
) (
  input  logic [Xw-1:0] i_current_x,
  input  logic [Yw-1:0] i_current_y,
  input  logic [Xw-1:0] i_dest_x,
  input  logic [Yw-1:0] i_dest_y,
  output logic [P-1:0]  o_destport
);

  localparam logic [Xw-1:0] X_MAX = Xw'(NX - 1);
  localparam logic [Yw-1:0] Y_MAX = Yw'(NY - 1);

  logic [Xw-1:0] w_dx;
  logic [Yw-1:0] w_dy;
  logic [P-1:0]  w_onehot;

  // Addresses beyond the mesh edge are steered toward the nearest edge
  // router rather than producing an undefined port.
  always_comb begin
    w_dx = (i_dest_x > X_MAX) ? X_MAX : i_dest_x;
    w_dy = (i_dest_y > Y_MAX) ? Y_MAX : i_dest_y;
  end

  always_comb begin
    w_onehot = LOCAL;
    if (w_dx > i_current_x)      w_onehot = EAST;
    else if (w_dx < i_current_x) w_onehot = WEST;
    else if (w_dy > i_current_y) w_onehot = SOUTH;
    else if (w_dy < i_current_y) w_onehot = NORTH;
    else                         w_onehot = LOCAL;
  end

  generate
    if (OUT_BIN) begin : g_bin
      logic [2:0] w_bin;
      always_comb begin
        w_bin = 3'd0;
        case (w_onehot)
          EAST:    w_bin = 3'd1;
          NORTH:   w_bin = 3'd2;
          WEST:    w_bin = 3'd3;
          SOUTH:   w_bin = 3'd4;
          default: w_bin = 3'd0;
        endcase
      end
      assign o_destport = {{(P-3){1'b0}}, w_bin};
    end else begin : g_onehot
      assign o_destport = w_onehot;
    end
  endgenerate

endmodule

// File: rtl/mesh_input_port.sv
// Input port of a 2D-mesh router: B-deep flit FIFO, head-flit decode,
// switch request and packet streaming.
//   clk, reset            clock, asynchronous active-high reset
//   current_x/current_y   this router's address (static)
//   flit_in, flit_in_wr   upstream flit and its write strobe
//   credit_out            one pulse per FIFO pop, one cycle after the pop
//   req                   one-hot switch request {S,W,N,E,L}, 0 = none
//   grant                 allocator grant, looked at only in REQ
//   flit_out              FIFO front (always driven)
//   flit_out_valid        front is offered to the crossbar (ACTIVE only)
//   flit_out_ready        crossbar takes flit_out this cycle
//   ovf_err               pulse: a write hit a full FIFO and was dropped
//   hdr_err               pulse: a non-head flit reached the front in IDLE
//   o_dbg_state           FSM state
//   o_dbg_count           FIFO occupancy
//
// Handshake: flit_out is transferred in a cycle where flit_out_valid and
// flit_out_ready are both 1; valid never depends on ready.
// Error pulses and credit_out are registered: they appear in the cycle
// after the event that caused them.
module mesh_input_port
  import noc_pkg::*;
#(
  parameter int NX = 4,
  parameter int NY = 3,
  parameter int Xw = 2,
  parameter int Yw = 2,
  parameter int Fw = 32,
  parameter int B  = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [Xw-1:0]       current_x,
  input  logic [Yw-1:0]       current_y,
  input  logic [Fw-1:0]       flit_in,
  input  logic                flit_in_wr,
  output logic                credit_out,
  output logic [P-1:0]        req,
  input  logic                grant,
  output logic [Fw-1:0]       flit_out,
  output logic                flit_out_valid,
  input  logic                flit_out_ready,
  output logic                ovf_err,
  output logic                hdr_err,
  output port_state_e         o_dbg_state,
  output logic [$clog2(B):0]  o_dbg_count
);

  localparam int AW        = $clog2(B);
  localparam int HEAD_BIT  = head_idx(Fw);
  localparam int TAIL_BIT  = tail_idx(Fw);
  localparam int DX_LSB    = dest_x_lsb();
  localparam int DY_LSB    = dest_y_lsb(Xw);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(B);

  // FIFO state
  logic [Fw-1:0] r_mem [B];
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [AW:0]   r_count;

  // FSM state and registered outputs
  port_state_e   r_state;
  logic [P-1:0]  r_dest;
  logic          r_credit;
  logic          r_ovf;
  logic          r_hdr;

  logic [Fw-1:0] w_front;
  logic          w_empty;
  logic          w_full;
  logic          w_head;
  logic          w_tail;
  logic          w_valid;
  logic          w_hdr_drop;
  logic          w_pop;
  logic          w_push;
  logic          w_ovf;
  logic [P-1:0]  w_destport;

  always_comb begin
    w_front    = r_mem[r_rd_ptr];
    w_empty    = (r_count == '0);
    w_full     = (r_count == FULL_CNT);
    w_head     = w_front[HEAD_BIT];
    w_tail     = w_front[TAIL_BIT];
    w_valid    = (r_state == ACTIVE) && !w_empty;
    // A packet must start with a head flit; anything else at the front
    // while idle is discarded so the port cannot lock up.
    w_hdr_drop = (r_state == IDLE) && !w_empty && !w_head;
    w_pop      = (w_valid && flit_out_ready) || w_hdr_drop;
    // A pop in the same cycle frees the slot, so a write to a full FIFO
    // is still accepted then.
    w_push     = flit_in_wr && (!w_full || w_pop);
    w_ovf      = flit_in_wr && w_full && !w_pop;
  end

  xy_mesh_routing #(
    .NX      (NX),
    .NY      (NY),
    .Xw      (Xw),
    .Yw      (Yw),
    .OUT_BIN (1'b0)
  ) u_route (
    .i_current_x (current_x),
    .i_current_y (current_y),
    .i_dest_x    (w_front[DX_LSB +: Xw]),
    .i_dest_y    (w_front[DY_LSB +: Yw]),
    .o_destport  (w_destport)
  );

  // Storage needs no reset: nothing reads it while count is 0.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= flit_in;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_dest   <= '0;
      r_credit <= 1'b0;
      r_ovf    <= 1'b0;
      r_hdr    <= 1'b0;
    end else begin
      r_credit <= w_pop;
      r_ovf    <= w_ovf;
      r_hdr    <= w_hdr_drop;
      case (r_state)
        IDLE: begin
          if (!w_empty && w_head) begin
            r_dest  <= w_destport;
            r_state <= REQ;
          end
        end
        REQ: begin
          if (grant) r_state <= ACTIVE;
        end
        ACTIVE: begin
          // The route stays latched until the tail actually leaves.
          if (w_pop && w_tail) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // req is held through ACTIVE so the allocator keeps the output locked.
  assign req            = (r_state == IDLE) ? '0 : r_dest;
  assign flit_out       = w_front;
  assign flit_out_valid = w_valid;
  assign credit_out     = r_credit;
  assign ovf_err        = r_ovf;
  assign hdr_err        = r_hdr;
  assign o_dbg_state    = r_state;
  assign o_dbg_count    = r_count;

endmodule

// File: tb/tb_mesh_input_port.sv
module tb_mesh_input_port;
  import noc_pkg::*;

  localparam int FW = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]    current_x = '0;
  logic [1:0]    current_y = '0;
  logic [FW-1:0] flit_in = '0;
  logic          flit_in_wr = 1'b0;
  logic          credit_out;
  logic [4:0]    req;
  logic          grant = 1'b0;
  logic [FW-1:0] flit_out;
  logic          flit_out_valid;
  logic          flit_out_ready = 1'b0;
  logic          ovf_err;
  logic          hdr_err;
  port_state_e   dbg_state;
  logic [2:0]    dbg_count;

  mesh_input_port #(
    .NX(4), .NY(3), .Xw(2), .Yw(2), .Fw(FW), .B(4)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .current_x      (current_x),
    .current_y      (current_y),
    .flit_in        (flit_in),
    .flit_in_wr     (flit_in_wr),
    .credit_out     (credit_out),
    .req            (req),
    .grant          (grant),
    .flit_out       (flit_out),
    .flit_out_valid (flit_out_valid),
    .flit_out_ready (flit_out_ready),
    .ovf_err        (ovf_err),
    .hdr_err        (hdr_err),
    .o_dbg_state    (dbg_state),
    .o_dbg_count    (dbg_count)
  );

  // ---------------- scoreboard / reference model ----------------
  int n_checks = 0;
  int n_fail   = 0;

  logic [FW-1:0] exp_q[$];     // expected FIFO contents, front first
  int            m_mode;       // 0 idle, 1 requesting, 2 streaming packet
  logic [4:0]    m_dest;
  logic          m_credit, m_ovf, m_hdr;
  int            cx, cy;
  int            obs_credit, obs_deliv;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // XY routing: resolve x first (east = larger x), then y (south = larger y).
  function automatic logic [4:0] ref_route(input int cur_x, input int cur_y,
                                           input int dx, input int dy);
    if (dx > cur_x) return 5'b00010;
    if (dx < cur_x) return 5'b01000;
    if (dy > cur_y) return 5'b10000;
    if (dy < cur_y) return 5'b00100;
    return 5'b00001;
  endfunction

  function automatic logic [FW-1:0] mk_flit(input logic h, input logic t,
                                            input int dx, input int dy);
    logic [FW-1:0] f;
    logic [31:0]   ax, ay;
    f = $urandom;
    ax = dx;
    ay = dy;
    f[31]  = h;
    f[30]  = t;
    f[1:0] = ax[1:0];
    f[3:2] = ay[1:0];
    return f;
  endfunction

  // ---------------- driver tasks ----------------
  // Called just after a rising edge: drive inputs, check at the falling
  // edge against the model, then advance the model across the next edge.
  task automatic cycle(input logic wr, input logic [FW-1:0] f,
                       input logic rdy, input logic gnt);
    logic          empty_m, full_m, vld, hdr_drop, pop, ovf;
    logic [FW-1:0] front;
    logic [4:0]    exp_req;
    flit_in        = f;
    flit_in_wr     = wr;
    flit_out_ready = rdy;
    grant          = gnt;
    @(negedge clk);
    empty_m  = (exp_q.size() == 0);
    full_m   = (exp_q.size() == 4);
    front    = empty_m ? '0 : exp_q[0];
    exp_req  = (m_mode != 0) ? m_dest : 5'd0;
    vld      = (m_mode == 2) && !empty_m;
    hdr_drop = (m_mode == 0) && !empty_m && !front[31];
    pop      = (vld && rdy) || hdr_drop;
    ovf      = wr && full_m && !pop;

    check("req",        32'(req),            32'(exp_req));
    check("valid",      32'(flit_out_valid), 32'(vld));
    check("credit",     32'(credit_out),     32'(m_credit));
    check("ovf_err",    32'(ovf_err),        32'(m_ovf));
    check("hdr_err",    32'(hdr_err),        32'(m_hdr));
    check("count",      32'(dbg_count),      32'(exp_q.size()));
    check("state",      32'(dbg_state),      32'(m_mode));
    if (!empty_m) check("flit_out", flit_out, front);

    obs_credit += int'(credit_out);
    obs_deliv  += int'(flit_out_valid && rdy);

    case (m_mode)
      0: if (!empty_m && front[31]) begin
           m_dest = ref_route(cx, cy, int'(front[1:0]), int'(front[3:2]));
           m_mode = 1;
         end
      1: if (gnt) m_mode = 2;
      default: if (pop && front[30]) m_mode = 0;
    endcase
    if (pop) void'(exp_q.pop_front());
    if (wr && !ovf) exp_q.push_back(f);
    m_credit = pop;
    m_ovf    = ovf;
    m_hdr    = hdr_drop;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic rdy, input logic gnt);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, rdy, gnt);
  endtask

  // Reset is asserted asynchronously in mid-cycle; outputs must clear at once.
  task automatic do_reset(input int x, input int y);
    #1 reset = 1'b1;
    current_x = 2'(x);
    current_y = 2'(y);
    flit_in_wr = 1'b0;
    grant = 1'b0;
    flit_out_ready = 1'b0;
    #1;
    check("rst_req",    32'(req),            32'd0);
    check("rst_valid",  32'(flit_out_valid), 32'd0);
    check("rst_credit", 32'(credit_out),     32'd0);
    check("rst_ovf",    32'(ovf_err),        32'd0);
    check("rst_hdr",    32'(hdr_err),        32'd0);
    check("rst_count",  32'(dbg_count),      32'd0);
    check("rst_state",  32'(dbg_state),      32'(IDLE));
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    cx = x;
    cy = y;
    exp_q.delete();
    m_mode = 0;
    m_dest = '0;
    m_credit = 1'b0;
    m_ovf = 1'b0;
    m_hdr = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int c0, d0;
    int pkt_left;
    logic wr, rdy, gnt;
    logic [FW-1:0] f;

    m_mode = 0; m_dest = '0; m_credit = 0; m_ovf = 0; m_hdr = 0;
    cx = 0; cy = 0; obs_credit = 0; obs_deliv = 0;
    #3;

    // Reset while streaming with two flits buffered.
    do_reset(1, 1);
    cycle(1'b1, mk_flit(1'b1, 1'b0, 3, 1), 1'b0, 1'b1);
    cycle(1'b1, mk_flit(1'b0, 1'b0, 0, 0), 1'b0, 1'b1);
    idle(3, 1'b0, 1'b1);
    check("pre_rst_state", 32'(dbg_state), 32'(ACTIVE));
    check("pre_rst_count", 32'(dbg_count), 32'd2);
    do_reset(1, 1);
    idle(2, 1'b1, 1'b1);

    // Three-flit packet routed east, ready and grant always high.
    c0 = obs_credit; d0 = obs_deliv;
    cycle(1'b1, mk_flit(1'b1, 1'b0, 3, 1), 1'b1, 1'b1);
    cycle(1'b1, mk_flit(1'b0, 1'b0, 2, 2), 1'b1, 1'b1);
    check("east_req", 32'(req), 32'h02);
    cycle(1'b1, mk_flit(1'b0, 1'b1, 1, 0), 1'b1, 1'b1);
    idle(6, 1'b1, 1'b1);
    check("east_credits", 32'(obs_credit - c0), 32'd3);
    check("east_deliv",   32'(obs_deliv - d0),  32'd3);

    // Single-flit packets: local, then south.
    do_reset(2, 0);
    cycle(1'b1, mk_flit(1'b1, 1'b1, 2, 0), 1'b1, 1'b1);
    cycle(1'b0, '0, 1'b1, 1'b1);
    check("local_req", 32'(req), 32'h01);
    idle(4, 1'b1, 1'b1);
    cycle(1'b1, mk_flit(1'b1, 1'b1, 2, 2), 1'b1, 1'b1);
    cycle(1'b0, '0, 1'b1, 1'b1);
    check("south_req", 32'(req), 32'h10);
    idle(4, 1'b1, 1'b1);

    // Grant withheld with a full FIFO, overflow, then write+pop while full.
    do_reset(0, 0);
    cycle(1'b1, mk_flit(1'b1, 1'b0, 3, 0), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, mk_flit(1'b0, 1'b0, 1, 1), 1'b0, 1'b0);
    idle(10, 1'b0, 1'b0);
    check("held_req", 32'(req), 32'h02);
    cycle(1'b1, mk_flit(1'b0, 1'b0, 0, 0), 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b1);
    cycle(1'b1, mk_flit(1'b0, 1'b0, 3, 3), 1'b1, 1'b0);
    check("full_wr_pop", 32'(dbg_count), 32'd4);
    cycle(1'b1, mk_flit(1'b0, 1'b1, 0, 1), 1'b1, 1'b0);
    idle(8, 1'b1, 1'b0);

    // Stray body flit in IDLE, then a normal head.
    do_reset(1, 1);
    cycle(1'b1, mk_flit(1'b0, 1'b0, 3, 2), 1'b1, 1'b1);
    idle(3, 1'b1, 1'b1);
    cycle(1'b1, mk_flit(1'b1, 1'b1, 1, 0), 1'b1, 1'b1);
    idle(5, 1'b1, 1'b1);

    // Random traffic: gaps, stalls, empty FIFO mid-packet, pointer wrap.
    for (int r = 0; r < 4; r++) begin
      do_reset(int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
      pkt_left = 0;
      for (int n = 0; n < 350; n++) begin
        wr  = ($urandom_range(0, 99) < 50);
        rdy = ($urandom_range(0, 99) < 60);
        gnt = ($urandom_range(0, 99) < 40);
        f   = '0;
        if (wr) begin
          if (pkt_left == 0) begin
            if ($urandom_range(0, 99) < 5) begin
              f = mk_flit(1'b0, 1'b0, 0, 0);
            end else begin
              pkt_left = int'($urandom_range(1, 4));
              f = mk_flit(1'b1, pkt_left == 1,
                          int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
              pkt_left--;
            end
          end else begin
            f = mk_flit(1'b0, pkt_left == 1, int'($urandom_range(0, 3)), 0);
            pkt_left--;
          end
        end
        cycle(wr, f, rdy, gnt);
      end
      idle(20, 1'b1, 1'b1);
    end

    // ---------------- report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
